// File: rtl/ps2_pkg.sv
// PS/2 shared types, command bytes and timing helper.
// Imported by the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE,
        DONE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LED   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] PS2_ACK_BYTE      = 8'hFA;

    function automatic int unsigned us_to_cycles(
        input int unsigned clk_hz,
        input int unsigned us
    );
        logic [63:0] prod;
        prod = 64'(clk_hz) * 64'(us);
        return 32'(prod / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer, glitch filter, fall strobe.
// Idle level is 1; used for both the clock and the data line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int unsigned   CW   = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip;

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        flip  = 1'b0;
        cnt_d = '0;
        if (s2_q != level_q) begin
            if (cnt_q == LAST) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q   <= line_i;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            fall_q <= flip & level_q;
            if (flip) begin
                level_q <= s2_q;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check and timeouts.
// Open-drain: the *_oe outputs only ever pull a line low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ            = 50_000_000,
    parameter int unsigned INHIBIT_US        = 120,
    parameter int unsigned START_TIMEOUT_US  = 15000,
    parameter int unsigned PACKET_TIMEOUT_US = 2000,
    parameter int unsigned FILTER_LEN        = 8
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    localparam int unsigned INH_CYC   = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int unsigned START_CYC = us_to_cycles(CLK_HZ, START_TIMEOUT_US);
    localparam int unsigned PKT_CYC   = us_to_cycles(CLK_HZ, PACKET_TIMEOUT_US);
    localparam int unsigned MAX_A     = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
    localparam int unsigned MAX_CYC   = (MAX_A > PKT_CYC) ? MAX_A : PKT_CYC;
    localparam int unsigned TW        = $clog2(MAX_CYC + 1);

    logic clk_lvl;
    logic clk_fall;
    logic data_lvl;
    logic unused_data_fall;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filt (
        .clk_i  (clk_50MHz),
        .rst_ni (reset),
        .line_i (ps2_clk_in),
        .level_o(clk_lvl),
        .fall_o (clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_data_filt (
        .clk_i  (clk_50MHz),
        .rst_ni (reset),
        .line_i (ps2_data_in),
        .level_o(data_lvl),
        .fall_o (unused_data_fall)
    );

    ps2_tx_state_e state_q;
    logic [TW-1:0] tmr_q;
    logic [3:0]    idx_q;
    logic [7:0]    data_q;
    logic          par_q;
    logic          ack_q;
    logic          ready_q;
    logic          inh_q;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          done_q;
    logic          ack_ok_q;
    logic          err_q;
    logic          timed;
    logic          expired;

    // One shared down-counter serves the inhibit time and both timeouts.
    assign timed   = (state_q == REQ) || (state_q == SHIFT) ||
                     (state_q == ACK) || (state_q == WAIT_IDLE);
    assign expired = timed && (tmr_q == '0);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            ack_q     <= 1'b0;
            ready_q   <= 1'b1;
            inh_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (expired) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            ack_ok_q  <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= DONE;
        end else begin
            if (timed) begin
                tmr_q <= tmr_q - 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        data_q    <= tx_data;
                        par_q     <= ~^tx_data;
                        tmr_q     <= TW'(INH_CYC - 1);
                        clk_oe_q  <= 1'b1;
                        data_oe_q <= (INH_CYC <= 1);
                        ready_q   <= 1'b0;
                        inh_q     <= 1'b1;
                        state_q   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (tmr_q == '0) begin
                        clk_oe_q <= 1'b0;
                        tmr_q    <= TW'(START_CYC - 1);
                        state_q  <= REQ;
                    end else begin
                        if (tmr_q == TW'(1)) begin
                            data_oe_q <= 1'b1;
                        end
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                REQ: begin
                    if (clk_fall) begin
                        idx_q   <= '0;
                        tmr_q   <= TW'(PKT_CYC - 1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_fall) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == 4'd9) begin
                            data_oe_q <= 1'b0;
                            state_q   <= ACK;
                        end else if (idx_q == 4'd8) begin
                            data_oe_q <= ~par_q;
                        end else begin
                            data_oe_q <= ~data_q[idx_q[2:0]];
                        end
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        ack_q   <= ~data_lvl;
                        state_q <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_lvl && data_lvl) begin
                        done_q   <= 1'b1;
                        ack_ok_q <= ack_q;
                        err_q    <= ~ack_q;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    ack_ok_q <= 1'b0;
                    err_q    <= 1'b0;
                    ready_q  <= 1'b1;
                    inh_q    <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = ready_q;
    assign rx_inhibit  = inh_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_ack_ok   = ack_ok_q;
    assign tx_error    = err_q;

endmodule
